tx_encoder: RTL and testbench
=============================

TX_ENCODER -- requirements
Module: tx_encoder

Interface
REQ-001 Parameter MAX_WORDS, default 380, max 32-bit beats per frame (1518 B rounded up); longer frames are truncated.
REQ-002 Parameter TXC_FLAG, default 32'hA000_0000, first control word (normal transmit, no checksum offload).
REQ-003 aclk  in  1  sole clock; all logic on rising edge.
REQ-004 aresetn  in  1  synchronous, active-low reset.
REQ-005 s_axis_packet_tdata/tstrb/tlast/tvalid  in  32/4/1/1  parsed-frame stream from the decoder stage.
REQ-006 s_axis_packet_tready  out  1  upstream backpressure.
REQ-007 m_axis_txc_tdata/tstrb/tlast/tvalid  out  32/4/1/1  MAC transmit-control stream.
REQ-008 m_axis_txc_tready  in  1.
REQ-009 m_axis_txd_tdata/tstrb/tlast/tvalid  out  32/4/1/1  MAC transmit-data stream.
REQ-010 m_axis_txd_tready  in  1.
REQ-011 tx_frames  out  32  frames completed on txd, wraps at 2^32.
REQ-012 tx_truncated  out  16  frames truncated at MAX_WORDS, saturates at 16'hFFFF.

Function
REQ-013 FSM states: IDLE, CTRL, DATA, DRAIN.
REQ-014 IDLE: s_tready=0, both master tvalid=0; when s_axis_packet_tvalid=1, go to CTRL next cycle; input beat is not consumed.
REQ-015 CTRL: m_axis_txc_tvalid=1, tstrb=4'hF; emit 6 words (word0=TXC_FLAG, words1-5=0); word index advances only on txc valid&ready.
REQ-016 CTRL: tlast=1 on word5 only; handshake of word5 -> DATA next cycle; s_tready=0 and txd_tvalid=0 throughout CTRL.
REQ-017 DATA: combinational pass-through, zero latency: txd_tdata/tstrb = s_tdata/tstrb, txd_tvalid = s_tvalid, s_tready = txd_tready.
REQ-018 DATA: beat counter (width clog2(MAX_WORDS)+1) counts accepted beats from 0; cleared on entry to CTRL.
REQ-019 DATA: txd_tlast = s_tlast OR (counter == MAX_WORDS-1).
REQ-020 Accepted beat with s_tlast=1 -> IDLE next cycle, tx_frames += 1.
REQ-021 Accepted beat with counter==MAX_WORDS-1 and s_tlast=0 -> DRAIN, tx_frames += 1, tx_truncated += 1 (saturating).
REQ-022 If s_tlast=1 coincides with counter==MAX_WORDS-1, frame is not truncated: IDLE, tx_truncated unchanged.
REQ-023 DRAIN: s_tready=1, txd_tvalid=0; input beats discarded until accepted s_tlast, then IDLE.
REQ-024 Master tdata/tstrb/tlast held stable while tvalid=1 and tready=0 (AXI-Stream rule); tvalid never drops before handshake.
REQ-025 Frames never interleave: a new txc sequence starts only from IDLE.
REQ-026 A 1-beat frame is legal: 6 txc words, then 1 txd word with tlast=1.

Reset
REQ-027 aresetn=0 sampled at a rising edge: FSM=IDLE, word index=0, beat counter=0, tx_frames=0, tx_truncated=0.
REQ-028 During reset and the first cycle after it, all tvalid outputs=0, s_axis_packet_tready=0, tdata/tstrb/tlast=0.
REQ-029 Reset mid-frame abandons the frame without tlast and without a counter update; the downstream MAC is reset by the same aresetn.

Structure
REQ-030 Shared package tx_encoder_pkg holds the FSM state enum, TXC_WORDS=6, and the default TXC_FLAG constant.
REQ-031 Single module, no sub-module; no data buffering beyond the 3-bit txc word index and the beat counter.

Verification
REQ-032 3-beat frame, both readies=1 -> txc A0000000,0,0,0,0,0 (tlast on 6th); txd 3 beats, tlast on 3rd; tx_frames=1.
REQ-033 txc_tready toggling 1/0 each cycle -> txc words in order, no duplicates or drops; s_tready stays 0 until DATA.
REQ-034 MAX_WORDS=4, 7-beat input -> txd 4 beats with forced tlast on 4th; beats 5-7 absorbed; tx_truncated=1; tx_frames=1.
REQ-035 MAX_WORDS=4, exactly 4-beat input -> no truncation, tx_truncated=0, next frame's txc starts from IDLE.
REQ-036 txd_tready=0 for 5 cycles mid-frame -> txd data stable, s_tready=0, no beat loss; resume completes frame.
REQ-037 aresetn=0 for 1 cycle during DATA beat 2 -> all valids 0 next cycle, counters 0; following frame encodes normally.

Source files
------------

// File: rtl/tx_encoder_pkg.sv
// Shared types and constants for the MAC transmit encoder.
package tx_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CTRL,
    ST_DATA,
    ST_DRAIN
  } state_e;

  localparam int          TXC_WORDS    = 6;
  localparam logic [31:0] TXC_FLAG_DEF = 32'hA000_0000;

endpackage

// File: rtl/tx_encoder.sv
// Wraps each parsed frame as a 6-word MAC control sequence followed by a
// zero-latency pass-through of the frame data, truncating at MAX_WORDS beats.
module tx_encoder
  import tx_encoder_pkg::*;
#(
  parameter int          MAX_WORDS = 380,
  parameter logic [31:0] TXC_FLAG  = TXC_FLAG_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_packet_tdata,
  input  logic [3:0]  s_axis_packet_tstrb,
  input  logic        s_axis_packet_tlast,
  input  logic        s_axis_packet_tvalid,
  output logic        s_axis_packet_tready,
  output logic [31:0] m_axis_txc_tdata,
  output logic [3:0]  m_axis_txc_tstrb,
  output logic        m_axis_txc_tlast,
  output logic        m_axis_txc_tvalid,
  input  logic        m_axis_txc_tready,
  output logic [31:0] m_axis_txd_tdata,
  output logic [3:0]  m_axis_txd_tstrb,
  output logic        m_axis_txd_tlast,
  output logic        m_axis_txd_tvalid,
  input  logic        m_axis_txd_tready,
  output logic [31:0] tx_frames,
  output logic [15:0] tx_truncated
);

  localparam int             CW        = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_WORDS - 1);
  localparam logic [2:0]     LAST_IDX  = 3'(TXC_WORDS - 1);

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   frames_q, frames_d;
  logic [15:0]   trunc_q, trunc_d;
  logic          at_max;

  assign at_max       = (cnt_q == LAST_BEAT);
  assign tx_frames    = frames_q;
  assign tx_truncated = trunc_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    trunc_d  = trunc_q;

    s_axis_packet_tready = 1'b0;
    m_axis_txc_tdata     = '0;
    m_axis_txc_tstrb     = '0;
    m_axis_txc_tlast     = 1'b0;
    m_axis_txc_tvalid    = 1'b0;
    m_axis_txd_tdata     = '0;
    m_axis_txd_tstrb     = '0;
    m_axis_txd_tlast     = 1'b0;
    m_axis_txd_tvalid    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Only peek at tvalid here; the first beat is consumed in DATA.
        if (s_axis_packet_tvalid) begin
          state_d = ST_CTRL;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_CTRL: begin
        m_axis_txc_tvalid = 1'b1;
        m_axis_txc_tstrb  = 4'hF;
        m_axis_txc_tdata  = (idx_q == 3'd0) ? TXC_FLAG : 32'd0;
        m_axis_txc_tlast  = (idx_q == LAST_IDX);
        if (m_axis_txc_tready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DATA: begin
        m_axis_txd_tdata     = s_axis_packet_tdata;
        m_axis_txd_tstrb     = s_axis_packet_tstrb;
        m_axis_txd_tvalid    = s_axis_packet_tvalid;
        m_axis_txd_tlast     = s_axis_packet_tlast | at_max;
        s_axis_packet_tready = m_axis_txd_tready;
        if (s_axis_packet_tvalid && m_axis_txd_tready) begin
          cnt_d = cnt_q + 1'b1;
          if (s_axis_packet_tlast) begin
            state_d  = ST_IDLE;
            frames_d = frames_q + 32'd1;
          end else if (at_max) begin
            state_d  = ST_DRAIN;
            frames_d = frames_q + 32'd1;
            if (trunc_q != 16'hFFFF) trunc_d = trunc_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        s_axis_packet_tready = 1'b1;
        if (s_axis_packet_tvalid && s_axis_packet_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Keep every output quiet while reset is asserted, regardless of state.
    if (!aresetn) begin
      s_axis_packet_tready = 1'b0;
      m_axis_txc_tdata     = '0;
      m_axis_txc_tstrb     = '0;
      m_axis_txc_tlast     = 1'b0;
      m_axis_txc_tvalid    = 1'b0;
      m_axis_txd_tdata     = '0;
      m_axis_txd_tstrb     = '0;
      m_axis_txd_tlast     = 1'b0;
      m_axis_txd_tvalid    = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
      trunc_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      trunc_q  <= trunc_d;
    end
  end

endmodule

// File: tb/tb_tx_encoder.sv
// Scoreboard bench for tx_encoder built with MAX_WORDS=4 so truncation is reachable.
module tb_tx_encoder;

  localparam int MAXW = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast, s_tvalid, s_tready;
  logic [31:0] txc_tdata, txd_tdata;
  logic [3:0]  txc_tstrb, txd_tstrb;
  logic        txc_tlast, txc_tvalid, txc_tready;
  logic        txd_tlast, txd_tvalid, txd_tready;
  logic [31:0] tx_frames;
  logic [15:0] tx_truncated;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_txc[$];
  beat_t exp_txd[$];
  int    exp_frames = 0;
  int    exp_trunc  = 0;
  bit    txc_toggle = 0;
  int    stall_cnt  = 0;
  int    stall_at   = -1;
  int    last_wait  = 0;

  tx_encoder #(.MAX_WORDS(MAXW)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_packet_tdata  (s_tdata),
    .s_axis_packet_tstrb  (s_tstrb),
    .s_axis_packet_tlast  (s_tlast),
    .s_axis_packet_tvalid (s_tvalid),
    .s_axis_packet_tready (s_tready),
    .m_axis_txc_tdata     (txc_tdata),
    .m_axis_txc_tstrb     (txc_tstrb),
    .m_axis_txc_tlast     (txc_tlast),
    .m_axis_txc_tvalid    (txc_tvalid),
    .m_axis_txc_tready    (txc_tready),
    .m_axis_txd_tdata     (txd_tdata),
    .m_axis_txd_tstrb     (txd_tstrb),
    .m_axis_txd_tlast     (txd_tlast),
    .m_axis_txd_tvalid    (txd_tvalid),
    .m_axis_txd_tready    (txd_tready),
    .tx_frames            (tx_frames),
    .tx_truncated         (tx_truncated)
  );

  always #5 aclk = ~aclk;

  // Downstream ready generator.
  always @(posedge aclk) begin
    #1;
    txc_tready = txc_toggle ? ~txc_tready : 1'b1;
    txd_tready = (stall_cnt > 0) ? 1'b0 : 1'b1;
    if (stall_cnt > 0) stall_cnt = stall_cnt - 1;
  end

  // Output monitor: scoreboard pops on handshake, AXI stability under stall.
  beat_t txc_hold, txd_hold, got;
  bit    txc_pend = 0, txd_pend = 0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      txc_pend = 0;
      txd_pend = 0;
    end else begin
      if (txc_tvalid) begin
        checks++;
        if (s_tready) begin
          errors++;
          $display("FAIL s_tready_in_ctrl got=%0b want=0", s_tready);
        end
      end
      if (txd_tvalid && !txd_tready) begin
        checks++;
        if (s_tready) begin
          errors++;
          $display("FAIL s_tready_in_stall got=%0b want=0", s_tready);
        end
      end
      got = '{d: txc_tdata, s: txc_tstrb, l: txc_tlast};
      if (txc_pend) begin
        checks++;
        if (!txc_tvalid || got !== txc_hold) begin
          errors++;
          $display("FAIL txc_stable got=%0b/%h want=1/%h", txc_tvalid, got, txc_hold);
        end
      end
      if (txc_tvalid && txc_tready) begin
        checks++;
        if (exp_txc.size() == 0) begin
          errors++;
          $display("FAIL txc_unexpected got=%h want=none", got);
        end else begin
          txc_hold = exp_txc.pop_front();
          if (got !== txc_hold) begin
            errors++;
            $display("FAIL txc_word got=%h want=%h", got, txc_hold);
          end
        end
        txc_pend = 0;
      end else begin
        txc_pend = txc_tvalid;
        txc_hold = got;
      end

      got = '{d: txd_tdata, s: txd_tstrb, l: txd_tlast};
      if (txd_pend) begin
        checks++;
        if (!txd_tvalid || got !== txd_hold) begin
          errors++;
          $display("FAIL txd_stable got=%0b/%h want=1/%h", txd_tvalid, got, txd_hold);
        end
      end
      if (txd_tvalid && txd_tready) begin
        checks++;
        if (exp_txd.size() == 0) begin
          errors++;
          $display("FAIL txd_unexpected got=%h want=none", got);
        end else begin
          txd_hold = exp_txd.pop_front();
          if (got !== txd_hold) begin
            errors++;
            $display("FAIL txd_beat got=%h want=%h", got, txd_hold);
          end
        end
        txd_pend = 0;
      end else begin
        txd_pend = txd_tvalid;
        txd_hold = got;
      end
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                            output bit ok);
    bit hs;
    s_tdata  = d;
    s_tstrb  = s;
    s_tlast  = l;
    s_tvalid = 1'b1;
    ok = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge aclk);
      hs = s_tready;
      @(posedge aclk);
      #1;
      if (hs) begin
        ok = 1;
        last_wait = c;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout got=no_ready want=ready data=%h", d);
    end
  endtask

  task automatic push_txc();
    for (int i = 0; i < 6; i++)
      exp_txc.push_back('{d: (i == 0) ? 32'hA000_0000 : 32'd0, s: 4'hF, l: (i == 5)});
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100; c++) begin
      if (exp_txc.size() == 0 && exp_txd.size() == 0) break;
      @(negedge aclk);
    end
    checks++;
    if (exp_txc.size() != 0 || exp_txd.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d want=0/0", exp_txc.size(), exp_txd.size());
    end
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    bit ok;
    logic [3:0] st;
    push_txc();
    for (int i = 0; i < n; i++) begin
      st = (i == n - 1) ? 4'h3 : 4'hF;
      if (i < MAXW) exp_txd.push_back('{d: base + i, s: st, l: (i == n - 1) || (i == MAXW - 1)});
    end
    exp_frames++;
    if (n > MAXW) exp_trunc++;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) stall_cnt = 5;
      st = (i == n - 1) ? 4'h3 : 4'hF;
      drive_beat(base + i, st, (i == n - 1), ok);
      if (!ok) break;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    wait_drain();
  endtask

  task automatic check_counters(input string name);
    @(negedge aclk);
    checks++;
    if (tx_frames !== 32'(exp_frames) || tx_truncated !== 16'(exp_trunc)) begin
      errors++;
      $display("FAIL %s_counters got=%0d/%0d want=%0d/%0d", name, tx_frames, tx_truncated,
               exp_frames, exp_trunc);
    end
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if ({txc_tvalid, txd_tvalid, s_tready, txc_tlast, txd_tlast} !== 5'b0 ||
        txc_tdata !== 32'd0 || txd_tdata !== 32'd0 || txc_tstrb !== 4'd0 || txd_tstrb !== 4'd0) begin
      errors++;
      $display("FAIL %s_quiet got=%0b%0b%0b/%h/%h want=000/0/0", name, txc_tvalid, txd_tvalid,
               s_tready, txc_tdata, txd_tdata);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_tdata = 32'hDEAD_BEEF; s_tstrb = 4'hF; s_tlast = 1'b1; s_tvalid = 1'b1;
    txc_tready = 1'b1; txd_tready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    check_quiet("in_reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(negedge aclk);
    check_quiet("post_reset");
    check_counters("reset");
    @(posedge aclk); #1;
  endtask

  task automatic test_basic();
    send_frame(3, 32'h1000_0000);
    check_counters("basic");
  endtask

  task automatic test_txc_toggle();
    txc_toggle = 1;
    send_frame(3, 32'h2000_0000);
    txc_toggle = 0;
    check_counters("txc_toggle");
  endtask

  task automatic test_truncate();
    send_frame(7, 32'h3000_0000);
    check_counters("truncate");
  endtask

  task automatic test_exact();
    send_frame(4, 32'h4000_0000);
    check_counters("exact");
  endtask

  task automatic test_one_beat();
    send_frame(1, 32'h5000_0000);
    check_counters("one_beat");
  endtask

  task automatic test_stall();
    stall_at = 1;
    send_frame(3, 32'h6000_0000);
    stall_at = -1;
    checks++;
    if (last_wait < 1) begin
      errors++;
      $display("FAIL stall_wait got=%0d want>=1", last_wait);
    end
    check_counters("stall");
  endtask

  task automatic test_back_to_back();
    send_frame(2, 32'h7000_0000);
    send_frame(5, 32'h7100_0000);
    check_counters("back_to_back");
  endtask

  task automatic test_mid_reset();
    bit ok;
    push_txc();
    exp_txd.push_back('{d: 32'h8000_0000, s: 4'hF, l: 1'b0});
    exp_txd.push_back('{d: 32'h8000_0001, s: 4'hF, l: 1'b0});
    drive_beat(32'h8000_0000, 4'hF, 1'b0, ok);
    drive_beat(32'h8000_0001, 4'hF, 1'b0, ok);
    s_tdata = 32'h8000_0002;
    aresetn = 1'b0;
    @(negedge aclk);
    check_quiet("mid_reset_low");
    @(posedge aclk); #1;
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    @(negedge aclk);
    check_quiet("mid_reset_after");
    checks++;
    if (exp_txc.size() != 0 || exp_txd.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_queue got=%0d/%0d want=0/0", exp_txc.size(), exp_txd.size());
    end
    exp_frames = 0;
    exp_trunc  = 0;
    check_counters("mid_reset");
    @(posedge aclk); #1;
  endtask

  task automatic test_after_reset();
    send_frame(2, 32'h9000_0000);
    check_counters("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_txc_toggle();
    test_truncate();
    test_exact();
    test_one_beat();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_after_reset();
    repeat (3) @(posedge aclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
